sorted_insert_ctrl: RTL

//   Sequencer for the indexed_rsh_arr datapath: keeps an ascending-sorted list of up to MAX_ELEM

---
 rtl/spmm_sort_pkg.sv | 17 +
 rtl/indexed_rsh_arr.sv | 30 +++
 rtl/sorted_insert_ctrl.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/spmm_sort_pkg.sv
// Shared types and sizing for the sorted insert controller.
// Holds the FSM state enum and the width derivations.
package spmm_sort_pkg;

  localparam int DATA_W   = 32;
  localparam int MAX_ELEM = 16;
  localparam int IDX_W    = $clog2(MAX_ELEM);
  localparam int CNT_W    = IDX_W + 1;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    SHIFT,
    DRAIN
  } state_e;

endpackage

// File: rtl/indexed_rsh_arr.sv
// Indexed right-shift insert: entry 0 is the MSB slice.
// arr_i/idx_i/ins_i in, arr_o = arr_i with ins_i placed at idx_i.
module indexed_rsh_arr #(
  parameter int DATA_W   = 32,
  parameter int MAX_ELEM = 16,
  parameter int IDX_W    = 4
) (
  input  logic [MAX_ELEM*DATA_W-1:0] arr_i,
  input  logic [IDX_W-1:0]           idx_i,
  input  logic [DATA_W-1:0]          ins_i,
  output logic [MAX_ELEM*DATA_W-1:0] arr_o
);

  always_comb begin
    arr_o = arr_i;
    // entries above idx move down one slot; the last one falls off
    for (int i = 1; i < MAX_ELEM; i++) begin
      if (int'(idx_i) < i) begin
        arr_o[(MAX_ELEM-i)*DATA_W-1 -: DATA_W] =
          arr_i[(MAX_ELEM-i+1)*DATA_W-1 -: DATA_W];
      end
    end
    for (int i = 0; i < MAX_ELEM; i++) begin
      if (int'(idx_i) == i) begin
        arr_o[(MAX_ELEM-i)*DATA_W-1 -: DATA_W] = ins_i;
      end
    end
  end

endmodule

// File: rtl/sorted_insert_ctrl.sv
// Ascending sorted list controller: insert via valid/ready,
// flush drains in order over valid/ready, then clears.
module sorted_insert_ctrl
  import spmm_sort_pkg::*;
#(
  parameter int DATA_W   = spmm_sort_pkg::DATA_W,
  parameter int MAX_ELEM = spmm_sort_pkg::MAX_ELEM,
  parameter int IDX_W    = $clog2(MAX_ELEM),
  parameter int CNT_W    = IDX_W + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  count,
  output logic              full,
  output logic              empty,
  output logic              busy
);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] bank_q [MAX_ELEM];
  logic [DATA_W-1:0] bank_d [MAX_ELEM];
  logic [CNT_W-1:0]  count_q, count_d;
  logic [CNT_W-1:0]  ptr_q, ptr_d;
  logic [CNT_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [DATA_W-1:0] ins_q, ins_d;
  logic              pend_q, pend_d;

  logic [MAX_ELEM*DATA_W-1:0] arr_flat;
  logic [MAX_ELEM*DATA_W-1:0] shr_flat;

  always_comb begin
    arr_flat = '0;
    for (int i = 0; i < MAX_ELEM; i++) begin
      arr_flat[(MAX_ELEM-i)*DATA_W-1 -: DATA_W] = bank_q[i];
    end
  end

  indexed_rsh_arr #(
    .DATA_W  (DATA_W),
    .MAX_ELEM(MAX_ELEM),
    .IDX_W   (IDX_W)
  ) u_shr (
    .arr_i(arr_flat),
    .idx_i(idx_q),
    .ins_i(ins_q),
    .arr_o(shr_flat)
  );

  assign count = count_q;
  assign full  = (count_q == CNT_W'(MAX_ELEM));
  assign empty = (count_q == '0);
  assign busy  = (state_q != IDLE) || pend_q;

  assign in_ready  = (state_q == IDLE) && !full && !pend_q;
  assign out_valid = (state_q == DRAIN) && (rd_ptr_q < count_q);
  assign out_data  = out_valid ?
                     bank_q[rd_ptr_q[IDX_W-1:0]] : '0;

  always_comb begin
    state_d  = state_q;
    bank_d   = bank_q;
    count_d  = count_q;
    ptr_d    = ptr_q;
    rd_ptr_d = rd_ptr_q;
    idx_d    = idx_q;
    ins_d    = ins_q;
    pend_d   = pend_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          ins_d   = in_data;
          ptr_d   = '0;
          state_d = SCAN;
          if (flush) pend_d = 1'b1;
        end else if (flush || pend_q) begin
          pend_d   = 1'b0;
          rd_ptr_d = '0;
          state_d  = DRAIN;
        end
      end
      SCAN: begin
        if (flush) pend_d = 1'b1;
        // strict less-than keeps equal values in arrival order
        if (ptr_q == count_q ||
            ins_q < bank_q[ptr_q[IDX_W-1:0]]) begin
          idx_d   = ptr_q[IDX_W-1:0];
          state_d = SHIFT;
        end else begin
          ptr_d = ptr_q + 1'b1;
        end
      end
      SHIFT: begin
        if (flush) pend_d = 1'b1;
        for (int i = 0; i < MAX_ELEM; i++) begin
          bank_d[i] = shr_flat[(MAX_ELEM-i)*DATA_W-1 -: DATA_W];
        end
        count_d = count_q + 1'b1;
        state_d = IDLE;
      end
      DRAIN: begin
        if (flush) pend_d = 1'b1;
        if (count_q == '0) begin
          state_d = IDLE;
        end else if (out_valid && out_ready) begin
          rd_ptr_d = rd_ptr_q + 1'b1;
          if (rd_ptr_q == count_q - 1'b1) begin
            for (int i = 0; i < MAX_ELEM; i++) begin
              bank_d[i] = '0;
            end
            count_d = '0;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      count_q  <= '0;
      ptr_q    <= '0;
      rd_ptr_q <= '0;
      idx_q    <= '0;
      ins_q    <= '0;
      pend_q   <= 1'b0;
      for (int i = 0; i < MAX_ELEM; i++) begin
        bank_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      ptr_q    <= ptr_d;
      rd_ptr_q <= rd_ptr_d;
      idx_q    <= idx_d;
      ins_q    <= ins_d;
      pend_q   <= pend_d;
      bank_q   <= bank_d;
    end
  end

endmodule
